// File: rtl/game_collision_arbiter_pkg.sv
// Shared defaults and widths for the Kong-vs-object collision arbiter.
package game_collision_pkg;
  localparam int N_CH_DEF            = 3;
  localparam int COOLDOWN_FRAMES_DEF = 30;
  localparam int CNT_W_DEF           = 8;
  // Cooldown counter is wide enough for the full 0..255 frame range.
  localparam int CD_W                = 8;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/game_collision_arbiter_if.sv
// Frame/pixel inputs and hit reporting outputs of the collision arbiter.
interface game_collision_arbiter_if
  import game_collision_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  localparam int IDX_W = idx_width(N_CH);

  logic                    startOfFrame;
  logic                    drawing_request_kong;
  logic [N_CH-1:0]         drawing_request;
  logic [N_CH-1:0]         channel_enable;
  logic                    clear_counts;
  logic [N_CH-1:0]         collision;
  logic [N_CH-1:0]         SingleHitPulse;
  logic                    hit_valid;
  logic [IDX_W-1:0]        hit_index;
  logic [N_CH-1:0]         cooldown_active;
  logic [N_CH*CNT_W-1:0]   hit_count;

  modport slave (
    input  startOfFrame, drawing_request_kong, drawing_request, channel_enable, clear_counts,
    output collision, SingleHitPulse, hit_valid, hit_index, cooldown_active, hit_count
  );

  modport master (
    output startOfFrame, drawing_request_kong, drawing_request, channel_enable, clear_counts,
    input  collision, SingleHitPulse, hit_valid, hit_index, cooldown_active, hit_count
  );
endinterface

// File: rtl/game_collision_arbiter_channel.sv
// One object channel: per-frame hit flag, frame cooldown, saturating hit counter, hit pulse.
module collision_channel
  import game_collision_pkg::*;
#(
  parameter int COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start_of_frame,
  input  logic             collision,
  input  logic             clear_counts,
  output logic             hit_accept,
  output logic             hit_pulse,
  output logic             cooldown_active,
  output logic [CNT_W-1:0] hit_count
);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES);

  logic            flag;
  logic [CD_W-1:0] cd_cnt;

  // Start of frame clears the flag in the same cycle, so a hit at pixel (0,0) counts.
  assign hit_accept      = collision && (start_of_frame || !flag) && (cd_cnt == '0);
  assign cooldown_active = (cd_cnt != '0);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      flag      <= 1'b0;
      cd_cnt    <= '0;
      hit_count <= '0;
      hit_pulse <= 1'b0;
    end else begin
      hit_pulse <= hit_accept;

      if (start_of_frame) flag <= hit_accept;
      else if (hit_accept) flag <= 1'b1;

      if (hit_accept) cd_cnt <= CD_LOAD;
      else if (start_of_frame && cd_cnt != '0) cd_cnt <= cd_cnt - CD_W'(1);

      if (clear_counts) hit_count <= hit_accept ? CNT_W'(1) : '0;
      else if (hit_accept && hit_count != '1) hit_count <= hit_count + CNT_W'(1);
    end
  end
endmodule

// File: rtl/game_collision_arbiter.sv
// Tests Kong against N_CH object channels; one hit per channel per frame with cooldown.
module game_collision_arbiter
  import game_collision_pkg::*;
#(
  parameter int N_CH            = N_CH_DEF,
  parameter int COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     resetN,
  game_collision_arbiter_if.slave  bus
);
  localparam int IDX_W = idx_width(N_CH);

  logic [N_CH-1:0]  accept;
  logic [IDX_W-1:0] nxt_idx;

  assign bus.collision = {N_CH{bus.drawing_request_kong}} & bus.drawing_request & bus.channel_enable;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    collision_channel #(
      .COOLDOWN_FRAMES (COOLDOWN_FRAMES),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clk             (clk),
      .resetN          (resetN),
      .start_of_frame  (bus.startOfFrame),
      .collision       (bus.collision[g]),
      .clear_counts    (bus.clear_counts),
      .hit_accept      (accept[g]),
      .hit_pulse       (bus.SingleHitPulse[g]),
      .cooldown_active (bus.cooldown_active[g]),
      .hit_count       (bus.hit_count[g*CNT_W +: CNT_W])
    );
  end

  // Lowest index wins; encoded from the accept vector so it lines up with the pulses.
  always_comb begin
    nxt_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (accept[i]) nxt_idx = IDX_W'(i);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bus.hit_valid <= 1'b0;
      bus.hit_index <= '0;
    end else begin
      bus.hit_valid <= |accept;
      bus.hit_index <= nxt_idx;
    end
  end
endmodule

// File: tb/tb_game_collision_arbiter.sv
// Directed bench: table of per-cycle vectors plus multi-frame cooldown and reset sequences.
module tb_game_collision_arbiter;
  logic clk = 1'b0;
  logic resetN;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  game_collision_arbiter_if #(.N_CH(3), .CNT_W(2)) ia ();
  game_collision_arbiter_if #(.N_CH(3), .CNT_W(8)) ib ();

  game_collision_arbiter #(.N_CH(3), .COOLDOWN_FRAMES(0), .CNT_W(2)) dut_a (
    .clk(clk), .resetN(resetN), .bus(ia));
  game_collision_arbiter #(.N_CH(3), .COOLDOWN_FRAMES(3), .CNT_W(8)) dut_b (
    .clk(clk), .resetN(resetN), .bus(ib));

  typedef struct {
    logic       sof, kong;
    logic [2:0] req, en;
    logic       clr;
    logic [2:0] coll, pulse;
    logic       valid;
    logic [1:0] idx;
    logic [5:0] cnt;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ia.startOfFrame = 0; ia.drawing_request_kong = 0; ia.drawing_request = 0;
    ia.channel_enable = 3'b111; ia.clear_counts = 0;
    ib.startOfFrame = 0; ib.drawing_request_kong = 0; ib.drawing_request = 0;
    ib.channel_enable = 3'b111; ib.clear_counts = 0;
  endtask

  task automatic chk_zero_a(input string nm);
    chk({nm, " a pulse"}, 32'(ia.SingleHitPulse), 0);
    chk({nm, " a valid"}, 32'(ia.hit_valid), 0);
    chk({nm, " a idx"},   32'(ia.hit_index), 0);
    chk({nm, " a cd"},    32'(ia.cooldown_active), 0);
    chk({nm, " a cnt"},   32'(ia.hit_count), 0);
  endtask

  task automatic chk_zero_b(input string nm);
    chk({nm, " b pulse"}, 32'(ib.SingleHitPulse), 0);
    chk({nm, " b valid"}, 32'(ib.hit_valid), 0);
    chk({nm, " b idx"},   32'(ib.hit_index), 0);
    chk({nm, " b cd"},    32'(ib.cooldown_active), 0);
    chk({nm, " b cnt"},   32'(ib.hit_count), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, first_at;
    //         sof   kong  req     en      clr   coll    pulse   v     idx   cnt {c2,c1,c0}
    tbl[0]  = '{1'b1, 1'b0, 3'b000, 3'b111, 1'b0, 3'b000, 3'b000, 1'b0, 2'd0, 6'b00_00_00};
    tbl[1]  = '{1'b0, 1'b1, 3'b001, 3'b111, 1'b0, 3'b001, 3'b001, 1'b1, 2'd0, 6'b00_00_01};
    tbl[2]  = '{1'b0, 1'b1, 3'b001, 3'b111, 1'b0, 3'b001, 3'b000, 1'b0, 2'd0, 6'b00_00_01};
    tbl[3]  = '{1'b0, 1'b1, 3'b110, 3'b111, 1'b0, 3'b110, 3'b110, 1'b1, 2'd1, 6'b01_01_01};
    tbl[4]  = '{1'b0, 1'b0, 3'b111, 3'b111, 1'b0, 3'b000, 3'b000, 1'b0, 2'd0, 6'b01_01_01};
    tbl[5]  = '{1'b1, 1'b1, 3'b001, 3'b111, 1'b0, 3'b001, 3'b001, 1'b1, 2'd0, 6'b01_01_10};
    tbl[6]  = '{1'b0, 1'b1, 3'b100, 3'b011, 1'b0, 3'b000, 3'b000, 1'b0, 2'd0, 6'b01_01_10};
    tbl[7]  = '{1'b0, 1'b1, 3'b100, 3'b111, 1'b0, 3'b100, 3'b100, 1'b1, 2'd2, 6'b10_01_10};
    tbl[8]  = '{1'b1, 1'b1, 3'b111, 3'b111, 1'b0, 3'b111, 3'b111, 1'b1, 2'd0, 6'b11_10_11};
    tbl[9]  = '{1'b1, 1'b1, 3'b001, 3'b111, 1'b0, 3'b001, 3'b001, 1'b1, 2'd0, 6'b11_10_11};
    tbl[10] = '{1'b1, 1'b1, 3'b001, 3'b111, 1'b0, 3'b001, 3'b001, 1'b1, 2'd0, 6'b11_10_11};
    tbl[11] = '{1'b1, 1'b1, 3'b001, 3'b111, 1'b1, 3'b001, 3'b001, 1'b1, 2'd0, 6'b00_00_01};
    tbl[12] = '{1'b0, 1'b0, 3'b000, 3'b111, 1'b1, 3'b000, 3'b000, 1'b0, 2'd0, 6'b00_00_00};
    tbl[13] = '{1'b0, 1'b1, 3'b011, 3'b111, 1'b0, 3'b011, 3'b010, 1'b1, 2'd1, 6'b00_01_00};
    tbl[14] = '{1'b0, 1'b1, 3'b010, 3'b111, 1'b0, 3'b010, 3'b000, 1'b0, 2'd0, 6'b00_01_00};

    resetN = 1'b0;
    idle_inputs();
    #2;
    chk_zero_a("reset");
    chk_zero_b("reset");
    @(negedge clk);
    resetN = 1'b1;

    // Cooldown disabled, 2-bit counters: per-cycle vectors
    for (int i = 0; i < 15; i++) begin
      ia.startOfFrame = tbl[i].sof; ia.drawing_request_kong = tbl[i].kong;
      ia.drawing_request = tbl[i].req; ia.channel_enable = tbl[i].en;
      ia.clear_counts = tbl[i].clr;
      #1;
      chk($sformatf("v%0d coll", i), 32'(ia.collision), 32'(tbl[i].coll));
      @(posedge clk); #1;
      chk($sformatf("v%0d pulse", i), 32'(ia.SingleHitPulse), 32'(tbl[i].pulse));
      chk($sformatf("v%0d valid", i), 32'(ia.hit_valid), 32'(tbl[i].valid));
      chk($sformatf("v%0d idx", i), 32'(ia.hit_index), 32'(tbl[i].idx));
      chk($sformatf("v%0d cnt", i), 32'(ia.hit_count), 32'(tbl[i].cnt));
      chk($sformatf("v%0d cd", i), 32'(ia.cooldown_active), 0);
      @(negedge clk);
    end
    idle_inputs();

    // 50 overlapping pixels in one frame yield a single pulse
    resetN = 1'b0; #1;
    chk_zero_a("rst2");
    @(negedge clk); resetN = 1'b1;
    ia.startOfFrame = 1; @(negedge clk); ia.startOfFrame = 0;
    pulses = 0; first_at = -1;
    for (int c = 0; c < 50; c++) begin
      ia.drawing_request_kong = 1; ia.drawing_request = 3'b001;
      @(posedge clk); #1;
      if (ia.SingleHitPulse[0]) begin
        pulses++;
        if (first_at < 0) first_at = c;
      end
      @(negedge clk);
    end
    idle_inputs();
    chk("50px pulses", 32'(pulses), 1);
    chk("50px first", 32'(first_at), 0);
    chk("50px cnt0", 32'(ia.hit_count[1:0]), 1);

    // Three-frame cooldown, overlap at each frame's first pixel
    for (int f = 0; f < 5; f++) begin
      ib.startOfFrame = 1; ib.drawing_request_kong = 1; ib.drawing_request = 3'b001;
      #1;
      chk($sformatf("cd f%0d active", f), 32'(ib.cooldown_active[0]), 32'(f >= 1 && f <= 3));
      @(posedge clk); #1;
      chk($sformatf("cd f%0d pulse", f), 32'(ib.SingleHitPulse), (f == 0 || f == 4) ? 1 : 0);
      @(negedge clk);
      ib.startOfFrame = 0; ib.drawing_request_kong = 0; ib.drawing_request = 0;
      @(negedge clk);
    end
    chk("cd hits", 32'(ib.hit_count[7:0]), 2);
    chk("cd others", 32'(ib.hit_count[23:8]), 0);
    chk("cd reload", 32'(ib.cooldown_active), 1);

    // Reset in the middle of a cooldown
    ib.startOfFrame = 1; @(negedge clk); ib.startOfFrame = 0;
    chk("mid cd", 32'(ib.cooldown_active[0]), 1);
    #2 resetN = 1'b0; #1;
    chk_zero_b("rst mid");
    @(negedge clk); resetN = 1'b1;
    ib.drawing_request_kong = 1; ib.drawing_request = 3'b001;
    @(posedge clk); #1;
    chk("post rst pulse", 32'(ib.SingleHitPulse), 1);
    chk("post rst valid", 32'(ib.hit_valid), 1);
    chk("post rst cd", 32'(ib.cooldown_active), 1);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/game_collision_arbiter.md
GAME_COLLISION_ARBITER -- requirements
Module: game_collision_arbiter

Interface
REQ-001 Parameter N_CH, default 3: number of object channels tested against Kong; legal range 1..16.
REQ-002 Parameter COOLDOWN_FRAMES, default 30: frames a channel stays blind after a hit; 0 disables cooldown; legal range 0..255.
REQ-003 Parameter CNT_W, default 8: width of each per-channel hit counter.
REQ-004 Ports, with clock and reset first:
  clk  in  1  system clock; one clock; reset is asynchronous and active-low.
  resetN  in  1  asynchronous active-low reset.
  startOfFrame  in  1  one-cycle pulse at frame start.
  drawing_request_kong  in  1  Kong pixel active.
  drawing_request  in  N_CH  per-object pixel active.
  channel_enable  in  N_CH  per-channel detection mask.
  clear_counts  in  1  synchronous clear of all hit counters.
  collision  out  N_CH  combinational per-channel overlap.
  SingleHitPulse  out  N_CH  registered one-cycle hit pulse per channel.
  hit_valid  out  1  registered; any SingleHitPulse bit high.
  hit_index  out  $clog2(N_CH) (min 1)  registered; lowest channel index pulsing.
  cooldown_active  out  N_CH  channel is currently blind.
  hit_count  out  N_CH*CNT_W  packed per-channel counters; channel i at bits [i*CNT_W +: CNT_W].

Function
REQ-005 collision[i] SHALL be drawing_request_kong AND drawing_request[i] AND channel_enable[i], combinationally.
REQ-006 A channel SHALL accept a hit when collision[i]=1, its frame flag is 0, and its cooldown counter is 0.
REQ-007 On an accepted hit, SingleHitPulse[i] SHALL be 1 in the following cycle only; the flag SHALL be set, the cooldown counter loaded with COOLDOWN_FRAMES, and hit_count[i] incremented.
REQ-008 At most one SingleHitPulse[i] SHALL occur per channel per frame, regardless of the number of overlapping pixels.
REQ-009 startOfFrame SHALL clear all flags; a collision in the same cycle SHALL be evaluated against the cleared flag, so a hit at pixel (0,0) is not lost.
REQ-010 On startOfFrame, each nonzero cooldown counter SHALL decrement by 1; a load in the same cycle SHALL take priority over the decrement.
REQ-011 cooldown_active[i] SHALL equal (cooldown counter[i] != 0).
REQ-012 hit_count[i] SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-013 clear_counts SHALL zero all counters next cycle; a hit in the same cycle SHALL leave the counter at 1.
REQ-014 hit_valid SHALL equal OR(SingleHitPulse), and hit_index SHALL be the lowest set index among simultaneous pulses; hit_index SHALL be 0 when hit_valid=0.
REQ-015 Deasserting channel_enable[i] SHALL suppress new hits only; the cooldown counter and hit counter of that channel SHALL be retained.
REQ-016 Channels SHALL be fully independent: a hit on one channel SHALL NOT affect the flag or cooldown of any other channel.

Reset
REQ-017 On resetN=0, asynchronously: all flags, cooldown counters, hit counters, SingleHitPulse, hit_valid and hit_index SHALL be 0.
REQ-018 Reset asserted mid-cooldown SHALL cancel the cooldown immediately; the first collision after release SHALL be accepted.

Structure
REQ-019 The shared package game_collision_pkg SHALL hold the default N_CH, COOLDOWN_FRAMES and CNT_W constants.
REQ-020 Per-channel logic (flag, cooldown counter, hit counter, pulse register) SHALL be a sub-module named collision_channel, instantiated N_CH times with a generate loop.
REQ-021 Priority encoding and hit_valid SHALL reside in the top level.

Verification
REQ-022 Channel 0 overlaps 50 pixels in one frame, COOLDOWN_FRAMES=0 -> exactly one SingleHitPulse[0], one cycle after the first overlap; hit_count[0]=1.
REQ-023 Channels 1 and 2 collide in the same cycle -> both pulses set; hit_valid=1; hit_index=1.
REQ-024 COOLDOWN_FRAMES=3, channel 0 overlaps on every frame -> hits accepted in frames 0 and 4 only; cooldown_active[0] high during frames 0-3.
REQ-025 Collision coincident with startOfFrame while the flag is set from the prior frame -> pulse issued next cycle.
REQ-026 CNT_W=2, five hits across frames -> hit_count stays at 3; clear_counts together with a hit -> count=1.
REQ-027 channel_enable[2]=0 while overlapping -> no pulse; re-enable within the same frame -> pulse on the next overlap; resetN pulse mid-cooldown -> all outputs 0.
